// File: rtl/logic_issue_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : logic_issue_unit_if                                     |
// | Brief    : Instruction, issue, write-back and debug signal bundle  |
// |            for the logical-path issue unit.                        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface logic_issue_unit_if #(
  parameter int WORD_SIZE = 19,
  parameter int ADDR_W    = 3
);
  // Instruction intake
  logic                 instr_valid;
  logic                 instr_ready;
  logic [WORD_SIZE-1:0] instr;
  // Issue to the logical unit
  logic                 iss_valid;
  logic                 iss_ready;
  logic [1:0]           iss_op;
  logic [WORD_SIZE-1:0] iss_operand_1;
  logic [WORD_SIZE-1:0] iss_operand_2;
  logic [ADDR_W-1:0]    iss_rd;
  // Result write-back
  logic                 wb_valid;
  logic [ADDR_W-1:0]    wb_rd;
  logic [WORD_SIZE-1:0] wb_data;
  // Status pulses
  logic                 illegal_op;
  logic                 wb_err;
  // Debug read port
  logic [ADDR_W-1:0]    dbg_addr;
  logic [WORD_SIZE-1:0] dbg_data;

  // Environment side: feeds instructions, accepts issues, returns results
  modport master (
    output instr_valid, instr, iss_ready, wb_valid, wb_rd, wb_data, dbg_addr,
    input  instr_ready, iss_valid, iss_op, iss_operand_1, iss_operand_2, iss_rd,
           illegal_op, wb_err, dbg_data
  );

  // Issue-unit side
  modport slave (
    input  instr_valid, instr, iss_ready, wb_valid, wb_rd, wb_data, dbg_addr,
    output instr_ready, iss_valid, iss_op, iss_operand_1, iss_operand_2, iss_rd,
           illegal_op, wb_err, dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/logic_issue_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : logic_issue_unit                                        |
// | Brief    : Decodes AND/OR/XOR/NOT instructions, reads operands     |
// |            from an 8-entry register file, issues them to the       |
// |            logical unit and retires results, with a busy-bit       |
// |            scoreboard stalling RAW/WAW hazards at decode.          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module logic_issue_unit #(
  parameter int WORD_SIZE = 19,
  parameter int NUM_REGS  = 8
) (
  input wire clk,
  input wire rst_n,
  logic_issue_unit_if.slave io
);

  localparam int         c_ADDR_W    = $clog2(NUM_REGS);
  // Instruction field positions (fixed for a 19-bit word)
  localparam int         c_OPC_MSB   = 18;
  localparam int         c_OPC_LSB   = 14;
  localparam int         c_RD_MSB    = 13;
  localparam int         c_RD_LSB    = 11;
  localparam int         c_RS1_MSB   = 10;
  localparam int         c_RS1_LSB   = 8;
  localparam int         c_RS2_MSB   = 7;
  localparam int         c_RS2_LSB   = 5;
  // Logical opcodes are 001xx; the low two bits are the issued op code
  localparam logic [2:0] c_OPC_CLASS = 3'b001;
  localparam logic [1:0] c_OP_NOT    = 2'b11;

  // Architectural state
  logic [WORD_SIZE-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]  r_busy;

  // Issue register and status pulses
  logic                 r_iss_valid;
  logic [1:0]           r_iss_op;
  logic [WORD_SIZE-1:0] r_iss_operand_1;
  logic [WORD_SIZE-1:0] r_iss_operand_2;
  logic [c_ADDR_W-1:0]  r_iss_rd;
  logic                 r_illegal_op;
  logic                 r_wb_err;

  // Decode fields
  logic [4:0]           w_opcode;
  logic [c_ADDR_W-1:0]  w_rd;
  logic [c_ADDR_W-1:0]  w_rs1;
  logic [c_ADDR_W-1:0]  w_rs2;
  logic                 w_legal;
  logic                 w_is_not;
  logic                 w_unused_bits;

  // Write-back / hazard / handshake
  logic                 w_wb_hit;
  logic [NUM_REGS-1:0]  w_wb_sel;
  logic [NUM_REGS-1:0]  w_busy_eff;
  logic                 w_hazard;
  logic                 w_slot_free;
  logic                 w_instr_ready;
  logic                 w_accept;
  logic                 w_accept_legal;
  logic                 w_fwd_1;
  logic                 w_fwd_2;
  logic [WORD_SIZE-1:0] w_operand_1;
  logic [WORD_SIZE-1:0] w_operand_2;

  assign w_opcode      = io.instr[c_OPC_MSB:c_OPC_LSB];
  assign w_rd          = io.instr[c_RD_MSB:c_RD_LSB];
  assign w_rs1         = io.instr[c_RS1_MSB:c_RS1_LSB];
  assign w_rs2         = io.instr[c_RS2_MSB:c_RS2_LSB];
  // Low instruction bits carry no meaning for the logical path
  assign w_unused_bits = ^io.instr[c_RS2_LSB-1:0];

  assign w_legal  = (w_opcode[4:2] == c_OPC_CLASS);
  assign w_is_not = (w_opcode[1:0] == c_OP_NOT);

  // A write-back only retires a tag that is actually outstanding
  assign w_wb_hit = io.wb_valid && r_busy[io.wb_rd];
  assign w_wb_sel = w_wb_hit ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << io.wb_rd) : '0;

  // Busy view seen by decode once this cycle's retirement is applied
  assign w_busy_eff = r_busy & ~w_wb_sel;

  assign w_hazard = w_busy_eff[w_rs1]
                 || (!w_is_not && w_busy_eff[w_rs2])
                 || w_busy_eff[w_rd];

  // Issue slot is free when empty or being drained this cycle
  assign w_slot_free    = !r_iss_valid || io.iss_ready;
  // Illegal opcodes are simply dropped, so they never wait on hazards
  assign w_instr_ready  = w_slot_free && (!w_legal || !w_hazard);
  assign w_accept       = io.instr_valid && w_instr_ready;
  assign w_accept_legal = w_accept && w_legal;

  // Same-cycle write-back bypasses the register file read
  assign w_fwd_1     = w_wb_hit && (io.wb_rd == w_rs1);
  assign w_fwd_2     = w_wb_hit && (io.wb_rd == w_rs2);
  assign w_operand_1 = w_fwd_1 ? io.wb_data : r_regs[w_rs1];
  assign w_operand_2 = w_is_not ? '0 : (w_fwd_2 ? io.wb_data : r_regs[w_rs2]);

  // Register file: only retiring write-backs update it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_hit) begin
      r_regs[io.wb_rd] <= io.wb_data;
    end
  end

  // Scoreboard: retire clears first, a same-cycle accept on that tag sets it again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (w_accept_legal) begin
      r_busy <= w_busy_eff | ({{(NUM_REGS-1){1'b0}}, 1'b1} << w_rd);
    end else begin
      r_busy <= w_busy_eff;
    end
  end

  // Issue register: load on legal accept, hold under backpressure, empty on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_valid     <= 1'b0;
      r_iss_op        <= '0;
      r_iss_operand_1 <= '0;
      r_iss_operand_2 <= '0;
      r_iss_rd        <= '0;
    end else if (w_accept_legal) begin
      r_iss_valid     <= 1'b1;
      r_iss_op        <= w_opcode[1:0];
      r_iss_operand_1 <= w_operand_1;
      r_iss_operand_2 <= w_operand_2;
      r_iss_rd        <= w_rd;
    end else if (io.iss_ready) begin
      r_iss_valid     <= 1'b0;
    end
  end

  // Single-cycle status pulses for dropped opcodes and stray write-backs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_op <= 1'b0;
      r_wb_err     <= 1'b0;
    end else begin
      r_illegal_op <= w_accept && !w_legal;
      r_wb_err     <= io.wb_valid && !r_busy[io.wb_rd];
    end
  end

  assign io.instr_ready   = w_instr_ready;
  assign io.iss_valid     = r_iss_valid;
  assign io.iss_op        = r_iss_op;
  assign io.iss_operand_1 = r_iss_operand_1;
  assign io.iss_operand_2 = r_iss_operand_2;
  assign io.iss_rd        = r_iss_rd;
  assign io.illegal_op    = r_illegal_op;
  assign io.wb_err        = r_wb_err;
  // Debug port shows committed contents only
  assign io.dbg_data      = r_regs[io.dbg_addr];

endmodule
`default_nettype wire
